// File: rtl/id_stage_ctrl_if.sv
// -----------------------------------------------------------------------------
// id_stage_ctrl_if
// Bundles the decode-stage control signals exchanged between the pipeline
// front end and the ID stage controller.
//   master : drives IR2, IR2Valid, EXPCSel, IR4; observes the controller outputs
//   slave  : the ID stage controller itself
// Signals
//   IR2        in   8      instruction currently in decode
//   IR2Valid   in   1      IR2 holds a real instruction
//   EXPCSel    in   1      0 = branch taken this cycle
//   IR4        in   8      instruction currently in MEM
//   IR3        out  8      instruction register driving EX control
//   PCWrite    out  1      fetch PC may advance
//   IR2Load    out  1      IR2 may load the next fetched instruction
//   IR2Flush   out  1      replace IR2 with NOP at the next edge
//   FwdA/FwdB  out  2      EX operand selects: 00 RF, 01 ALUOut, 10 WB data
//   StallCount out  CNT_W  saturating load-use stall counter
//   FlushCount out  CNT_W  saturating taken-branch flush counter
// -----------------------------------------------------------------------------
interface id_stage_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [7:0]       IR2;
   logic             IR2Valid;
   logic             EXPCSel;
   logic [7:0]       IR4;
   logic [7:0]       IR3;
   logic             PCWrite;
   logic             IR2Load;
   logic             IR2Flush;
   logic [1:0]       FwdA;
   logic [1:0]       FwdB;
   logic [CNT_W-1:0] StallCount;
   logic [CNT_W-1:0] FlushCount;

   modport master (
      output IR2, IR2Valid, EXPCSel, IR4,
      input  IR3, PCWrite, IR2Load, IR2Flush, FwdA, FwdB, StallCount, FlushCount
   );

   modport slave (
      input  IR2, IR2Valid, EXPCSel, IR4,
      output IR3, PCWrite, IR2Load, IR2Flush, FwdA, FwdB, StallCount, FlushCount
   );
endinterface

// File: rtl/id_stage_ctrl.sv
// -----------------------------------------------------------------------------
// id_stage_ctrl
// Decode/register-fetch stage control for the 8-bit 5-stage pipeline.
// Owns IR3, detects load-use hazards (one-cycle stall), flushes wrong-path
// instructions on a taken branch, registers the EX forwarding selects and
// keeps saturating stall/flush event counters.
// Ports
//   clock  in  1   rising-edge clock
//   reset  in  1   synchronous, active-high reset
//   bus    slave modport of id_stage_ctrl_if (see that file for signal list)
// -----------------------------------------------------------------------------
module id_stage_ctrl #(
   parameter logic [7:0] NOP_INSTR = 8'b00001010,
   parameter int         CNT_W     = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   id_stage_ctrl_if.slave       bus
);

   // Decoded view of one instruction: which operands it reads and where it writes.
   typedef struct packed {
      logic       use_a;
      logic       use_b;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic       has_dst;
      logic [1:0] dst;
      logic       is_load;
   } dec_t;

   function automatic dec_t decode(input logic [7:0] ir);
      dec_t d;
      d.use_a   = 1'b0;
      d.use_b   = 1'b0;
      d.src_a   = ir[7:6];
      d.src_b   = ir[5:4];
      d.has_dst = 1'b0;
      d.dst     = ir[7:6];
      d.is_load = 1'b0;
      case (ir[3:0])
         4'b0000: begin                      // load
            d.use_a   = 1'b1;
            d.use_b   = 1'b1;
            d.has_dst = 1'b1;
            d.is_load = 1'b1;
         end
         4'b0010: begin                      // store
            d.use_a = 1'b1;
            d.use_b = 1'b1;
         end
         4'b0100, 4'b0110, 4'b1000: begin    // add, sub, nand
            d.use_a   = 1'b1;
            d.use_b   = 1'b1;
            d.has_dst = 1'b1;
         end
         4'b0011, 4'b1011: begin             // shift
            d.use_a   = 1'b1;
            d.has_dst = 1'b1;
         end
         4'b0111, 4'b1111: begin             // ori: implicit r1 source and destination
            d.use_a   = 1'b1;
            d.src_a   = 2'b01;
            d.has_dst = 1'b1;
            d.dst     = 2'b01;
         end
         default: begin                      // nop, branches, undefined
         end
      endcase
      return d;
   endfunction

   // Forwarding select for one operand; the EX result wins over MEM because it
   // is the younger producer. A load in EX cannot forward (its data is not
   // ready yet), which is exactly the case the stall covers.
   function automatic logic [1:0] fwd_sel(input logic used, input logic [1:0] src,
                                          input dec_t ex, input dec_t mem);
      logic [1:0] sel;
      sel = 2'b00;
      if (used) begin
         if (ex.has_dst && ex.dst == src && !ex.is_load)
            sel = 2'b01;
         else if (mem.has_dst && mem.dst == src)
            sel = 2'b10;
      end
      return sel;
   endfunction

   logic [7:0]       ir3_q, ir3_d;
   logic [1:0]       fwd_a_q, fwd_a_d;
   logic [1:0]       fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic [7:0] ir2_eff;
   dec_t       dec2, dec3, dec4;
   logic       stall, flush;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // An invalid IR2 is treated as a NOP so it neither stalls nor forwards.
   assign ir2_eff = bus.IR2Valid ? bus.IR2 : NOP_INSTR;
   assign dec2    = decode(ir2_eff);
   assign dec3    = decode(ir3_q);
   assign dec4    = decode(bus.IR4);

   assign stall = bus.IR2Valid && dec3.is_load &&
                  ((dec2.use_a && dec2.src_a == dec3.dst) ||
                   (dec2.use_b && dec2.src_b == dec3.dst));
   assign flush = !bus.EXPCSel;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         ir3_q       <= NOP_INSTR;
         fwd_a_q     <= 2'b00;
         fwd_b_q     <= 2'b00;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ir3_q       <= ir3_d;
         fwd_a_q     <= fwd_a_d;
         fwd_b_q     <= fwd_b_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Next-state: flush beats stall; both insert a bubble into IR3.
   always_comb begin
      ir3_d       = ir2_eff;
      fwd_a_d     = fwd_sel(dec2.use_a, dec2.src_a, dec3, dec4);
      fwd_b_d     = fwd_sel(dec2.use_b, dec2.src_b, dec3, dec4);
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (flush) begin
         ir3_d   = NOP_INSTR;
         fwd_a_d = 2'b00;
         fwd_b_d = 2'b00;
         if (flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else if (stall) begin
         ir3_d   = NOP_INSTR;
         fwd_a_d = 2'b00;
         fwd_b_d = 2'b00;
         if (stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
   end

   // Front-end control outputs
   always_comb begin
      bus.PCWrite  = 1'b1;
      bus.IR2Load  = 1'b1;
      bus.IR2Flush = 1'b0;
      if (reset) begin
         bus.PCWrite = 1'b0;
         bus.IR2Load = 1'b0;
      end else if (flush) begin
         bus.IR2Flush = 1'b1;
      end else if (stall) begin
         bus.PCWrite = 1'b0;
         bus.IR2Load = 1'b0;
      end
   end

   assign bus.IR3        = ir3_q;
   assign bus.FwdA       = fwd_a_q;
   assign bus.FwdB       = fwd_b_q;
   assign bus.StallCount = stall_cnt_q;
   assign bus.FlushCount = flush_cnt_q;

endmodule
